// File: rtl/eeprom_test_ctrl.sv
// eeprom_test_ctrl: write/read-back test sequencer driving the iic_com EEPROM byte engine.
// Define EEPROM_TEST_TIMEOUT_EN to build the per-transaction watchdog (Timeout output).
module eeprom_test_ctrl #(
  parameter int unsigned NUM_BYTES      = 8,
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [7:0]  DATA_XOR       = 8'hA5,
  parameter int unsigned TWR_CYCLES     = 250000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig,
  output logic       Busy,
  output logic       Pass,
  output logic       Fail,
  output logic [7:0] Err_Addr,
  output logic [7:0] Err_Data,
  output logic       Timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_GAP, S_RD_REQ, S_CMP, S_DONE
  } state_t;

  localparam logic [1:0]  CMD_IDLE = 2'b00;
  localparam logic [1:0]  CMD_WR   = 2'b01;
  localparam logic [1:0]  CMD_RD   = 2'b10;
  localparam logic [8:0]  LAST_IDX = 9'(NUM_BYTES - 1);
  localparam logic [23:0] TWR_LAST = 24'(TWR_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  start_sig_q;
  logic [7:0]  addr_q, wrdata_q, rd_q, err_addr_q, err_data_q;
  logic        busy_q, pass_q, fail_q;
  logic [8:0]  idx_q;
  logic [23:0] dly_q;
  logic [7:0]  addr_inc;

  // Address advances with idx and wraps modulo 256 naturally.
  assign addr_inc = addr_q + 8'd1;

`ifdef EEPROM_TEST_TIMEOUT_EN
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wd_q;
  logic        timeout_q;
  logic        wd_hit;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                        wd_q <= '0;
    else if (state_q == S_WR_REQ || state_q == S_RD_REQ) wd_q <= wd_q + 24'd1;
    else                                              wd_q <= '0;
  end

  assign wd_hit  = (wd_q == WD_LAST);
  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      start_sig_q <= CMD_IDLE;
      addr_q      <= '0;
      wrdata_q    <= '0;
      rd_q        <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      idx_q       <= '0;
      dly_q       <= '0;
`ifdef EEPROM_TEST_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            idx_q       <= '0;
            addr_q      <= BASE_ADDR;
            wrdata_q    <= BASE_ADDR ^ DATA_XOR;
            busy_q      <= 1'b1;
            start_sig_q <= CMD_WR;
            state_q     <= S_WR_REQ;
`ifdef EEPROM_TEST_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        S_WR_REQ: begin
          if (Done_Sig) begin
            start_sig_q <= CMD_IDLE;
            dly_q       <= '0;
            state_q     <= S_WR_WAIT;
          end
`ifdef EEPROM_TEST_TIMEOUT_EN
          else if (wd_hit) begin
            start_sig_q <= CMD_IDLE;
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            err_addr_q  <= addr_q;
            err_data_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
`endif
        end
        S_WR_WAIT: begin
          if (dly_q == TWR_LAST) begin
            dly_q <= '0;
            if (idx_q == LAST_IDX) begin
              idx_q    <= '0;
              addr_q   <= BASE_ADDR;
              wrdata_q <= BASE_ADDR ^ DATA_XOR;
              state_q  <= S_RD_GAP;
            end else begin
              idx_q       <= idx_q + 9'd1;
              addr_q      <= addr_inc;
              wrdata_q    <= addr_inc ^ DATA_XOR;
              start_sig_q <= CMD_WR;
              state_q     <= S_WR_REQ;
            end
          end else begin
            dly_q <= dly_q + 24'd1;
          end
        end
        S_RD_GAP: begin
          start_sig_q <= CMD_RD;
          state_q     <= S_RD_REQ;
        end
        S_RD_REQ: begin
          if (Done_Sig) begin
            rd_q        <= RdData;
            start_sig_q <= CMD_IDLE;
            state_q     <= S_CMP;
          end
`ifdef EEPROM_TEST_TIMEOUT_EN
          else if (wd_hit) begin
            start_sig_q <= CMD_IDLE;
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            err_addr_q  <= addr_q;
            err_data_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
`endif
        end
        S_CMP: begin
          // wrdata_q still holds addr ^ DATA_XOR, i.e. the expected byte.
          if (rd_q != wrdata_q) begin
            err_addr_q <= addr_q;
            err_data_q <= rd_q;
            fail_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else if (idx_q == LAST_IDX) begin
            pass_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q    <= idx_q + 9'd1;
            addr_q   <= addr_inc;
            wrdata_q <= addr_inc ^ DATA_XOR;
            state_q  <= S_RD_GAP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Start_Sig = start_sig_q;
  assign Addr_Sig  = addr_q;
  assign WrData    = wrdata_q;
  assign Busy      = busy_q;
  assign Pass      = pass_q;
  assign Fail      = fail_q;
  assign Err_Addr  = err_addr_q;
  assign Err_Data  = err_data_q;

endmodule

// File: tb/tb_eeprom_test_ctrl.sv
// Bench for eeprom_test_ctrl: two instances (base 00/8 bytes, base FE/4 bytes) each with a
// behavioural iic_com+EEPROM model; table-driven runs plus hang/reset/watchdog sequences.
module tb_eeprom_test_ctrl;

  localparam int TWR   = 20;
  localparam int LAT   = 3;
  localparam int BOUND = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b, done_a, done_b;
  logic [1:0] sig_a, sig_b;
  logic [7:0] addr_a, wd_a, rd_a, ea_a, ed_a;
  logic [7:0] addr_b, wd_b, rd_b, ea_b, ed_b;
  logic       busy_a, pass_a, fail_a, to_a;
  logic       busy_b, pass_b, fail_b, to_b;
  logic       mute, corrupt;
  logic [7:0] c_addr;
  int         total, bad, viol;

  eeprom_test_ctrl #(.NUM_BYTES(8), .BASE_ADDR(8'h00), .DATA_XOR(8'hA5),
                     .TWR_CYCLES(TWR), .TIMEOUT_CYCLES(1000)) dut_a (
    .CLK(clk), .RSTn(rst_n), .Start(start_a), .Start_Sig(sig_a), .Addr_Sig(addr_a),
    .WrData(wd_a), .RdData(rd_a), .Done_Sig(done_a), .Busy(busy_a), .Pass(pass_a),
    .Fail(fail_a), .Err_Addr(ea_a), .Err_Data(ed_a), .Timeout(to_a));

  eeprom_test_ctrl #(.NUM_BYTES(4), .BASE_ADDR(8'hFE), .DATA_XOR(8'hA5),
                     .TWR_CYCLES(TWR), .TIMEOUT_CYCLES(1000)) dut_b (
    .CLK(clk), .RSTn(rst_n), .Start(start_b), .Start_Sig(sig_b), .Addr_Sig(addr_b),
    .WrData(wd_b), .RdData(rd_b), .Done_Sig(done_b), .Busy(busy_b), .Pass(pass_b),
    .Fail(fail_b), .Err_Addr(ea_b), .Err_Data(ed_b), .Timeout(to_b));

  logic [37:0] outs_a;
  assign outs_a = {sig_a, addr_a, wd_a, busy_a, pass_a, fail_a, ea_a, ed_a, to_a};

  // Behavioural iic_com + EEPROM: Done after LAT busy cycles, then waits for Start_Sig=0.
  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [3:0]  cnt_a, cnt_b;
  logic        low_a, low_b;
  logic [15:0] wq_a [$];
  logic [15:0] wq_b [$];
  logic [7:0]  rq_a [$];
  logic [7:0]  rq_b [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0; low_a <= 1'b0; done_a <= 1'b0; rd_a <= '0;
    end else begin
      done_a <= 1'b0;
      if (low_a) begin
        if (sig_a == 2'b00) low_a <= 1'b0;
      end else if (sig_a != 2'b00 && !mute) begin
        if (cnt_a == 4'(LAT)) begin
          cnt_a <= '0; done_a <= 1'b1; low_a <= 1'b1;
          if (sig_a == 2'b01) begin
            mem_a[addr_a] <= wd_a;
            wq_a.push_back({addr_a, wd_a});
          end else begin
            rd_a <= (corrupt && addr_a == c_addr) ? 8'h00 : mem_a[addr_a];
            rq_a.push_back(addr_a);
          end
        end else cnt_a <= cnt_a + 4'd1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b <= '0; low_b <= 1'b0; done_b <= 1'b0; rd_b <= '0;
    end else begin
      done_b <= 1'b0;
      if (low_b) begin
        if (sig_b == 2'b00) low_b <= 1'b0;
      end else if (sig_b != 2'b00 && !mute) begin
        if (cnt_b == 4'(LAT)) begin
          cnt_b <= '0; done_b <= 1'b1; low_b <= 1'b1;
          if (sig_b == 2'b01) begin
            mem_b[addr_b] <= wd_b;
            wq_b.push_back({addr_b, wd_b});
          end else begin
            rd_b <= (corrupt && addr_b == c_addr) ? 8'h00 : mem_b[addr_b];
            rq_b.push_back(addr_b);
          end
        end else cnt_b <= cnt_b + 4'd1;
      end
    end
  end

  // Handshake monitor, sampled on the falling edge.
  logic       pdone_a, pdone_b, lastw_a;
  logic [1:0] psig_a, psig_b;
  int         zr_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      pdone_a = 1'b0; pdone_b = 1'b0; psig_a = '0; psig_b = '0; zr_a = 0; lastw_a = 1'b0;
    end else begin
      if (sig_a == 2'b11 || sig_b == 2'b11) viol++;
      if (pdone_a && sig_a != 2'b00) viol++;
      if (pdone_b && sig_b != 2'b00) viol++;
      if (psig_a != 2'b00 && sig_a != 2'b00 && sig_a != psig_a) viol++;
      if (psig_b != 2'b00 && sig_b != 2'b00 && sig_b != psig_b) viol++;
      if (sig_a == 2'b00) zr_a++;
      else begin
        if (psig_a == 2'b00 && lastw_a && zr_a < TWR) viol++;
        lastw_a = (sig_a == 2'b01);
        zr_a = 0;
      end
      pdone_a = done_a; pdone_b = done_b; psig_a = sig_a; psig_b = sig_b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input string name);
    int n;
    n = 0;
    while ((which ? busy_b : busy_a) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= BOUND) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  typedef struct {
    bit         which;
    bit         corrupt;
    logic [7:0] c_addr;
    bit         poke;
    logic       exp_pass;
    logic       exp_fail;
    logic [7:0] exp_eaddr;
    logic [7:0] exp_edata;
    int         exp_reads;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t        vecs [7];
    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    logic [7:0]  base, ea;
    int          nbytes, seqbad;

    total = 0; bad = 0; viol = 0;
    mute = 1'b0; corrupt = 1'b0; c_addr = '0;
    start_a = 1'b0; start_b = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8};
    vecs[1] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 6};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1};
    vecs[4] = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3};

    repeat (3) @(negedge clk);
    check("reset_outs_a", 64'(outs_a), 64'h0);
    check("reset_busy_b", {busy_b, pass_b, fail_b, sig_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      corrupt = vecs[i].corrupt;
      c_addr  = vecs[i].c_addr;
      wq_a.delete(); rq_a.delete(); wq_b.delete(); rq_b.delete();
      pulse_start(vecs[i].which);
      if (vecs[i].poke) begin
        repeat (30) @(negedge clk);
        pulse_start(1'b0);
      end
      wait_idle(vecs[i].which, $sformatf("v%0d_idle", i));
      @(negedge clk);
      if (vecs[i].which) begin
        check($sformatf("v%0d_pass", i), pass_b, vecs[i].exp_pass);
        check($sformatf("v%0d_fail", i), fail_b, vecs[i].exp_fail);
        check($sformatf("v%0d_eaddr", i), ea_b, vecs[i].exp_eaddr);
        check($sformatf("v%0d_edata", i), ed_b, vecs[i].exp_edata);
        check($sformatf("v%0d_timeout", i), to_b, 0);
        check($sformatf("v%0d_sig", i), sig_b, 0);
        wq = wq_b; rq = rq_b; base = 8'hFE; nbytes = 4;
      end else begin
        check($sformatf("v%0d_pass", i), pass_a, vecs[i].exp_pass);
        check($sformatf("v%0d_fail", i), fail_a, vecs[i].exp_fail);
        check($sformatf("v%0d_eaddr", i), ea_a, vecs[i].exp_eaddr);
        check($sformatf("v%0d_edata", i), ed_a, vecs[i].exp_edata);
        check($sformatf("v%0d_timeout", i), to_a, 0);
        check($sformatf("v%0d_sig", i), sig_a, 0);
        wq = wq_a; rq = rq_a; base = 8'h00; nbytes = 8;
      end
      check($sformatf("v%0d_nwrites", i), wq.size(), nbytes);
      check($sformatf("v%0d_nreads", i), rq.size(), vecs[i].exp_reads);
      seqbad = 0;
      for (int k = 0; k < wq.size() && k < nbytes; k++) begin
        ea = base + 8'(k);
        if (wq[k] !== {ea, ea ^ 8'hA5}) seqbad++;
      end
      for (int k = 0; k < rq.size() && k < vecs[i].exp_reads; k++) begin
        ea = base + 8'(k);
        if (rq[k] !== ea) seqbad++;
      end
      check($sformatf("v%0d_addr_seq", i), seqbad, 0);
    end

    // Silent NACK: controller keeps requesting; then reset mid-WR_REQ.
    corrupt = 1'b0;
    mute = 1'b1;
    pulse_start(1'b0);
    repeat (200) @(negedge clk);
    check("hang_busy", busy_a, 1);
    check("hang_sig", sig_a, 2'b01);
    check("hang_fail", fail_a, 0);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", 64'(outs_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
    @(negedge clk);
    pulse_start(1'b0);
    wait_idle(1'b0, "post_reset_idle");
    @(negedge clk);
    check("post_reset_pass", pass_a, 1);
    check("post_reset_fail", fail_a, 0);

`ifdef EEPROM_TEST_TIMEOUT_EN
    begin
      int n;
      mute = 1'b1;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      n = 0;
      while (!fail_a && n < 3000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("to_cycles", n, 1000);
      check("to_fail", fail_a, 1);
      check("to_timeout", to_a, 1);
      check("to_pass", pass_a, 0);
      check("to_eaddr", ea_a, 8'h00);
      check("to_edata", ed_a, 8'h00);
      check("to_sig", sig_a, 2'b00);
      check("to_busy", busy_a, 0);
      mute = 1'b0;
    end
`endif

    repeat (5) @(negedge clk);
    check("handshake_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
